// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the 3-input gate truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int NUM_VECTORS = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  // Vector 000 lands in the MSB so the captured word reads like the gate's hex code.
  function automatic logic [2:0] vec_to_bit(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_sync2.sv
// Generic 2-flop synchroniser for asynchronous gate outputs.
module truth_table_sweeper_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate through all 8 vectors, samples its output after a
// settle time and compares the assembled truth-table word to an expected code.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       match
);

  generate
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 3");
    end
    if (CNT_W < 31 && (1 << CNT_W) <= SETTLE_CYCLES) begin : g_bad_cnt_w
      $error("CNT_W too narrow for SETTLE_CYCLES");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_VECTORS - 1);

  state_e           state, state_nxt;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       exp_q;
  logic             dut_sync;

  truth_table_sweeper_sync2 #(.W(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (dut_sync)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == LAST_IDX) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort wins over every transition, but only once a sweep is running
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      exp_q <= '0;
      truth <= '0;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort && state != IDLE) begin
        idx   <= '0;
        match <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            exp_q <= expected;
            truth <= '0;
            match <= 1'b0;
            idx   <= '0;
            cnt   <= CNT_LOAD;
          end
          SETTLE: if (cnt != '0) cnt <= cnt - CNT_W'(1);
          SAMPLE: begin
            truth[vec_to_bit(idx)] <= dut_sync;
            if (idx != LAST_IDX) begin
              idx <= idx + 3'd1;
              cnt <= CNT_LOAD;
            end
          end
          DONE: begin
            match <= (truth == exp_q);
            idx   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  logic drive_vec;
  assign drive_vec = (state == SETTLE) || (state == SAMPLE);
  assign {drv_in1, drv_in2, drv_in3} = drive_vec ? idx : 3'b000;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
